// File: rtl/ad9361_rx_stim_gen.sv
// ad9361_rx_stim_gen
//   AD9361 LVDS receive-bus stimulus source. Emits framed 12-bit I/Q samples
//   as four 6-bit nibbles per sample (I[11:6], Q[11:6], I[5:0], Q[5:0]) with
//   rx_frame high for the MSB half. Patterns: ramp, PN15, constant; bursts
//   are either counted (burst_len != 0) or continuous until stop.
//
//   Optional feature macro: AD9361_RX_STIM_ERR_INJ_EN adds input err_inject,
//   a one-shot that flips I[0] of the next sample latched.
//
// Ports
//   clk, rst            nibble-rate clock, synchronous active-high reset
//   start, stop         burst start pulse (IDLE only) / stop at sample boundary
//   mode                0 ramp, 1 PN15, 2/3 constant
//   const_i, const_q    constant-mode sample values
//   burst_len           samples per burst, 0 = continuous
//   busy, done          RUN indicator / one-cycle completion pulse
//   sample_cnt          samples fully emitted in the current burst
//   rx_frame, rx_data   framed nibble output bus
module ad9361_rx_stim_gen #(
    parameter logic [14:0] PN_SEED   = 15'h7fff,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [1:0]           mode,
    input  logic [11:0]          const_i,
    input  logic [11:0]          const_q,
    input  logic [CNT_WIDTH-1:0] burst_len,
`ifdef AD9361_RX_STIM_ERR_INJ_EN
    input  logic                 err_inject,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] sample_cnt,
    output logic                 rx_frame,
    output logic [5:0]           rx_data
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    // x^15 + x^14 + 1 Fibonacci LFSR advanced 12 steps (one sample's worth).
    function automatic logic [14:0] lfsr_adv12(input logic [14:0] s);
        logic [14:0] t;
        t = s;
        for (int k = 0; k < 12; k++) begin
            t = {t[13:0], t[14] ^ t[13]};
        end
        return t;
    endfunction

    function automatic logic [5:0] nib_sel(input logic [11:0] i, input logic [11:0] q,
                                           input logic [1:0] n);
        logic [5:0] r;
        case (n)
            2'd0:    r = i[11:6];
            2'd1:    r = q[11:6];
            2'd2:    r = i[5:0];
            default: r = q[5:0];
        endcase
        return r;
    endfunction

    logic                 state_q, state_d;
    logic [1:0]           nib_q, nib_d;
    logic [11:0]          i_q, i_d, q_q, q_d;
    logic [11:0]          ramp_q, ramp_d;
    logic [14:0]          lfsr_q, lfsr_d;
    logic [CNT_WIDTH-1:0] blen_q, blen_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 stop_pend_q, stop_pend_d;
    logic                 done_q, done_d;
    logic                 frame_q, frame_d;
    logic [5:0]           data_q, data_d;
    logic                 armed_q, armed_d;

    logic                 latch;
    logic                 err_pulse;
    logic [11:0]          ramp_src;
    logic [14:0]          lfsr_src, lfsr_nxt;
    logic [11:0]          new_i, new_q;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [1:0]           nib_inc;
    logic                 burst_end;

`ifdef AD9361_RX_STIM_ERR_INJ_EN
    assign err_pulse = err_inject;
`else
    assign err_pulse = 1'b0;
`endif

    always_comb begin
        // A start restarts ramp and PN sequences from their origin; mid-burst
        // samples continue from the running generator state.
        ramp_src = (state_q == ST_IDLE) ? 12'h000 : ramp_q;
        lfsr_src = (state_q == ST_IDLE) ? PN_SEED : lfsr_q;
        lfsr_nxt = lfsr_adv12(lfsr_src);
        case (mode)
            2'd0: begin
                new_i = ramp_src;
                new_q = ~ramp_src;
            end
            2'd1: begin
                new_i = lfsr_src[11:0];
                new_q = lfsr_nxt[11:0];
            end
            default: begin
                new_i = const_i;
                new_q = const_q;
            end
        endcase
        new_i = new_i ^ {11'd0, armed_q};

        cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
        nib_inc   = nib_q + 2'd1;
        burst_end = ((blen_q != '0) && (cnt_inc >= blen_q)) || stop_pend_q || stop;

        state_d     = state_q;
        nib_d       = nib_q;
        i_d         = i_q;
        q_d         = q_q;
        ramp_d      = ramp_q;
        lfsr_d      = lfsr_q;
        blen_d      = blen_q;
        cnt_d       = cnt_q;
        stop_pend_d = stop_pend_q;
        done_d      = 1'b0;
        frame_d     = frame_q;
        data_d      = data_q;
        latch       = 1'b0;

        if (state_q == ST_IDLE) begin
            if (start) begin
                state_d     = ST_RUN;
                cnt_d       = '0;
                stop_pend_d = 1'b0;
                latch       = 1'b1;
            end
        end else begin
            stop_pend_d = stop_pend_q | stop;
            if (nib_q == 2'd3) begin
                cnt_d = cnt_inc;
                if (burst_end) begin
                    state_d     = ST_IDLE;
                    done_d      = 1'b1;
                    nib_d       = 2'd0;
                    frame_d     = 1'b0;
                    data_d      = 6'd0;
                    stop_pend_d = 1'b0;
                end else begin
                    latch = 1'b1;
                end
            end else begin
                nib_d   = nib_inc;
                frame_d = (nib_inc == 2'd1);
                data_d  = nib_sel(i_q, q_q, nib_inc);
            end
        end

        // Controls are captured only when a new sample is latched, so
        // mid-sample changes take effect at the next nibble 0.
        if (latch) begin
            i_d     = new_i;
            q_d     = new_q;
            ramp_d  = ramp_src + 12'd1;
            lfsr_d  = lfsr_nxt;
            blen_d  = burst_len;
            nib_d   = 2'd0;
            frame_d = 1'b1;
            data_d  = new_i[11:6];
        end

        armed_d = (armed_q & ~latch) | err_pulse;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            nib_q       <= 2'd0;
            i_q         <= 12'd0;
            q_q         <= 12'd0;
            ramp_q      <= 12'd0;
            lfsr_q      <= PN_SEED;
            blen_q      <= '0;
            cnt_q       <= '0;
            stop_pend_q <= 1'b0;
            done_q      <= 1'b0;
            frame_q     <= 1'b0;
            data_q      <= 6'd0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            nib_q       <= nib_d;
            i_q         <= i_d;
            q_q         <= q_d;
            ramp_q      <= ramp_d;
            lfsr_q      <= lfsr_d;
            blen_q      <= blen_d;
            cnt_q       <= cnt_d;
            stop_pend_q <= stop_pend_d;
            done_q      <= done_d;
            frame_q     <= frame_d;
            data_q      <= data_d;
            armed_q     <= armed_d;
        end
    end

    assign busy       = (state_q == ST_RUN);
    assign done       = done_q;
    assign sample_cnt = cnt_q;
    assign rx_frame   = frame_q;
    assign rx_data    = data_q;

endmodule

// File: tb/tb_ad9361_rx_stim_gen.sv
module tb_ad9361_rx_stim_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [11:0] const_i = 12'd0;
    logic [11:0] const_q = 12'd0;
    logic [15:0] burst_len = 16'd0;
`ifdef AD9361_RX_STIM_ERR_INJ_EN
    logic        err_inject = 1'b0;
`endif
    logic        busy, done, rx_frame;
    logic [15:0] sample_cnt;
    logic [5:0]  rx_data;

    int pass_cnt = 0;
    int total_cnt = 0;

    ad9361_rx_stim_gen dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .const_i(const_i), .const_q(const_q), .burst_len(burst_len),
`ifdef AD9361_RX_STIM_ERR_INJ_EN
        .err_inject(err_inject),
`endif
        .busy(busy), .done(done), .sample_cnt(sample_cnt),
        .rx_frame(rx_frame), .rx_data(rx_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: sample idx of a burst, {I,Q}. PN bits are produced one at a
    // time from the 7fff seed; each sample consumes 12 new bits.
    function automatic logic [23:0] exp_iq(input int m, input logic [11:0] ci,
                                           input logic [11:0] cq, input int idx);
        logic [11:0] i, q;
        logic [14:0] s;
        if (m == 0) begin
            i = 12'(idx);
            q = ~i;
        end else if (m == 1) begin
            s = 15'h7fff;
            for (int k = 0; k < 12 * idx; k++) s = {s[13:0], s[14] ^ s[13]};
            i = s[11:0];
            for (int k = 0; k < 12; k++) s = {s[13:0], s[14] ^ s[13]};
            q = s[11:0];
        end else begin
            i = ci;
            q = cq;
        end
        return {i, q};
    endfunction

    function automatic logic [5:0] exp_nib(input logic [23:0] iq, input int n);
        logic [5:0] r;
        case (n)
            0: r = iq[23:18];
            1: r = iq[11:6];
            2: r = iq[17:12];
            default: r = iq[5:0];
        endcase
        return r;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) tick();
        total_cnt++;
        if ({busy, done, sample_cnt, rx_frame, rx_data} !== 25'd0)
            $display("FAIL reset_outputs got busy=%b done=%b cnt=%0d frame=%b data=%h exp all 0",
                     busy, done, sample_cnt, rx_frame, rx_data);
        else pass_cnt++;
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            total_cnt++;
            if (rx_data !== 6'd0 || rx_frame !== 1'b0 || busy !== 1'b0)
                $display("FAIL idle_hold c%0d got data=%h frame=%b busy=%b exp 0", c, rx_data, rx_frame, busy);
            else pass_cnt++;
        end
    endtask

    task automatic test_ramp_burst();
        logic [5:0] tbl [12] = '{6'h00, 6'h3f, 6'h00, 6'h3f, 6'h00, 6'h3f,
                                 6'h01, 6'h3e, 6'h00, 6'h3f, 6'h02, 6'h3d};
        logic [3:0] frm = 4'b1100;
        mode = 2'd0;
        burst_len = 16'd3;
        pulse_start();
        for (int k = 0; k < 12; k++) begin
            total_cnt++;
            if (rx_data !== tbl[k] || rx_frame !== frm[3 - (k % 4)] || busy !== 1'b1 || done !== 1'b0)
                $display("FAIL ramp3 k%0d got data=%h frame=%b busy=%b done=%b exp data=%h frame=%b",
                         k, rx_data, rx_frame, busy, done, tbl[k], frm[3 - (k % 4)]);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (done !== 1'b1 || busy !== 1'b0 || sample_cnt !== 16'd3 || rx_data !== 6'd0)
            $display("FAIL ramp3_end got done=%b busy=%b cnt=%0d data=%h exp 1 0 3 00",
                     done, busy, sample_cnt, rx_data);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (done !== 1'b0) $display("FAIL ramp3_done_pulse got %b exp 0", done);
        else pass_cnt++;
    endtask

    task automatic test_const_stop();
        logic [5:0] tbl [4] = '{6'h2a, 6'h04, 6'h3c, 6'h23};
        int dones = 0;
        mode = 2'd2;
        const_i = 12'hABC;
        const_q = 12'h123;
        burst_len = 16'd0;
        pulse_start();
        for (int k = 0; k < 16; k++) begin
            total_cnt++;
            if (rx_data !== tbl[k % 4] || busy !== 1'b1)
                $display("FAIL const k%0d got data=%h busy=%b exp data=%h busy=1", k, rx_data, busy, tbl[k % 4]);
            else pass_cnt++;
            if (k == 13) stop = 1'b1;
            tick();
            stop = 1'b0;
        end
        total_cnt++;
        if (done !== 1'b1 || busy !== 1'b0 || sample_cnt !== 16'd4)
            $display("FAIL const_stop_end got done=%b busy=%b cnt=%0d exp 1 0 4", done, busy, sample_cnt);
        else pass_cnt++;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        total_cnt++;
        if (dones != 0 || busy !== 1'b0 || rx_data !== 6'd0)
            $display("FAIL const_stop_once got extra_done=%0d busy=%b data=%h exp 0 0 00", dones, busy, rx_data);
        else pass_cnt++;
    endtask

    task automatic test_pn_rst();
        logic [5:0] e;
        int dones = 0;
        mode = 2'd1;
        burst_len = 16'd100;
        pulse_start();
        for (int k = 0; k < 4 * 50 + 2; k++) begin
            e = exp_nib(exp_iq(1, 12'd0, 12'd0, k / 4), k % 4);
            total_cnt++;
            if (rx_data !== e || rx_frame !== ((k % 4) < 2))
                $display("FAIL pn k%0d got data=%h frame=%b exp data=%h", k, rx_data, rx_frame, e);
            else pass_cnt++;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++;
        if ({busy, done, sample_cnt, rx_frame, rx_data} !== 25'd0)
            $display("FAIL pn_rst got busy=%b done=%b cnt=%0d frame=%b data=%h exp all 0",
                     busy, done, sample_cnt, rx_frame, rx_data);
        else pass_cnt++;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        total_cnt++;
        if (dones != 0) $display("FAIL pn_rst_no_done got %0d done pulses exp 0", dones);
        else pass_cnt++;
        burst_len = 16'd1;
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            e = exp_nib(exp_iq(1, 12'd0, 12'd0, 0), k);
            total_cnt++;
            if (rx_data !== e) $display("FAIL pn_restart k%0d got %h exp %h", k, rx_data, e);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (done !== 1'b1) $display("FAIL pn_restart_done got %b exp 1", done);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [5:0] e;
        mode = 2'd0;
        burst_len = 16'd4;
        pulse_start();
        for (int k = 0; k < 16; k++) begin
            e = exp_nib(exp_iq(0, 12'd0, 12'd0, k / 4), k % 4);
            total_cnt++;
            if (rx_data !== e || busy !== 1'b1)
                $display("FAIL start_in_run k%0d got data=%h busy=%b exp %h 1", k, rx_data, busy, e);
            else pass_cnt++;
            start = (k == 6);
            tick();
            start = 1'b0;
        end
        total_cnt++;
        if (done !== 1'b1 || sample_cnt !== 16'd4)
            $display("FAIL b2b_end got done=%b cnt=%0d exp 1 4", done, sample_cnt);
        else pass_cnt++;
        // Restart in the same cycle done is high: fresh ramp from 0.
        burst_len = 16'd2;
        pulse_start();
        for (int k = 0; k < 8; k++) begin
            e = exp_nib(exp_iq(0, 12'd0, 12'd0, k / 4), k % 4);
            total_cnt++;
            if (rx_data !== e) $display("FAIL b2b_restart k%0d got %h exp %h", k, rx_data, e);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (done !== 1'b1 || sample_cnt !== 16'd2)
            $display("FAIL b2b_restart_end got done=%b cnt=%0d exp 1 2", done, sample_cnt);
        else pass_cnt++;
        tick();
        start = 1'b1;
        rst = 1'b1;
        tick();
        start = 1'b0;
        rst = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || rx_data !== 6'd0 || rx_frame !== 1'b0 || sample_cnt !== 16'd0)
            $display("FAIL start_rst got busy=%b data=%h frame=%b cnt=%0d exp 0", busy, rx_data, rx_frame, sample_cnt);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL start_rst_idle got busy=%b exp 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_len_change();
        logic [5:0] e;
        mode = 2'd0;
        burst_len = 16'd5;
        pulse_start();
        burst_len = 16'd1;
        // Latched length 5 holds for sample 0; new length 1 is picked up at
        // sample 1's nibble 0, so the burst ends after two samples.
        for (int k = 0; k < 8; k++) begin
            e = exp_nib(exp_iq(0, 12'd0, 12'd0, k / 4), k % 4);
            total_cnt++;
            if (rx_data !== e || busy !== 1'b1 || done !== 1'b0)
                $display("FAIL len_change k%0d got data=%h busy=%b done=%b exp %h 1 0", k, rx_data, busy, done, e);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (done !== 1'b1 || busy !== 1'b0 || sample_cnt !== 16'd2)
            $display("FAIL len_change_end got done=%b busy=%b cnt=%0d exp 1 0 2", done, busy, sample_cnt);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_random();
        logic [5:0] e;
        int m, len;
        for (int it = 0; it < 8; it++) begin
            m = int'($urandom_range(0, 3));
            len = int'($urandom_range(1, 8));
            mode = 2'(m);
            const_i = 12'($urandom);
            const_q = 12'($urandom);
            burst_len = 16'(len);
            pulse_start();
            for (int k = 0; k < 4 * len; k++) begin
                e = exp_nib(exp_iq(m, const_i, const_q, k / 4), k % 4);
                total_cnt++;
                if (rx_data !== e || rx_frame !== ((k % 4) < 2) || busy !== 1'b1)
                    $display("FAIL rand it%0d m%0d k%0d got data=%h frame=%b busy=%b exp %h",
                             it, m, k, rx_data, rx_frame, busy, e);
                else pass_cnt++;
                tick();
            end
            total_cnt++;
            if (done !== 1'b1 || sample_cnt !== 16'(len))
                $display("FAIL rand_end it%0d got done=%b cnt=%0d exp 1 %0d", it, done, sample_cnt, len);
            else pass_cnt++;
            repeat (int'($urandom_range(1, 3))) tick();
        end
    endtask

`ifdef AD9361_RX_STIM_ERR_INJ_EN
    task automatic test_err_inj();
        logic [23:0] iq;
        logic [5:0] e;
        mode = 2'd0;
        burst_len = 16'd8;
        pulse_start();
        for (int k = 0; k < 32; k++) begin
            iq = exp_iq(0, 12'd0, 12'd0, k / 4);
            if (k / 4 == 6) iq[12] = ~iq[12];
            e = exp_nib(iq, k % 4);
            total_cnt++;
            if (rx_data !== e) $display("FAIL err_inj k%0d got %h exp %h", k, rx_data, e);
            else pass_cnt++;
            err_inject = (k == 21 || k == 22);
            tick();
            err_inject = 1'b0;
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_ramp_burst();
        tick();
        test_const_stop();
        test_pn_rst();
        test_back_to_back();
        test_len_change();
        test_random();
`ifdef AD9361_RX_STIM_ERR_INJ_EN
        test_err_inj();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
